// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the input PIO: Avalon word addresses and edge-select encodings.
package soc_system_pio_pkg;

  typedef logic [1:0] pio_addr_t;

  localparam pio_addr_t ADDR_DATA    = 2'd0;
  localparam pio_addr_t ADDR_RSVD    = 2'd1;
  localparam pio_addr_t ADDR_IRQMASK = 2'd2;
  localparam pio_addr_t ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// Single-bit debouncer: the output follows the input only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive cycles.
module soc_system_pio_debounce
  import soc_system_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          filt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b0;
    end else if (raw == filt_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      filt_reg <= raw;
      cnt_reg  <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign filt = filt_reg;

endmodule

// File: rtl/soc_system_input_pio_irq.sv
// Avalon-MM input PIO with synchroniser, sticky edge capture and masked level irq.
// Define SOC_SYSTEM_PIO_DEBOUNCE_EN to insert a per-bit debouncer after the synchroniser.
module soc_system_input_pio_irq
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

`ifdef SOC_SYSTEM_PIO_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif

  // Edges stay masked until the sync chain (and debouncer) hold post-reset data.
  localparam int PRIME_CYCLES = SYNC_STAGES + 1 + (DEBOUNCE_EN ? DEBOUNCE_CYCLES : 0);
  localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] data_filt;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] irqmask_reg;
  logic [PRIME_W-1:0] prime_reg;
  logic             primed;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
    end
  end

  assign data_sync = sync_reg[SYNC_STAGES-1];

`ifdef SOC_SYSTEM_PIO_DEBOUNCE_EN
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
      soc_system_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (data_sync[gi]),
        .filt    (data_filt[gi])
      );
    end
  endgenerate
`else
  assign data_filt = data_sync;
`endif

  assign rise = data_filt & ~prev_reg;
  assign fall = ~data_filt & prev_reg;

  always_comb begin
    edge_sel = rise;
    case (EDGE_TYPE)
      EDGE_FALL: edge_sel = fall;
      EDGE_ANY:  edge_sel = rise | fall;
      default:   edge_sel = rise;
    endcase
  end

  assign primed       = (prime_reg == PRIME_LAST);
  assign edge_hit     = primed ? edge_sel : '0;
  assign wr_en        = chipselect & ~write_n;
  assign clear_bits   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  // A new edge outranks a simultaneous clear so no event is lost.
  assign edgecap_next = (edgecap_reg & ~clear_bits) | edge_hit;
  assign unused_wdata = &{1'b0, writedata};

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = data_filt;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask_reg;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap_reg;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg    <= '0;
      prime_reg   <= '0;
      edgecap_reg <= '0;
      irqmask_reg <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      prev_reg    <= data_filt;
      if (!primed) begin
        prime_reg <= prime_reg + 1'b1;
      end
      edgecap_reg <= edgecap_next;
      if (wr_en && address == ADDR_IRQMASK) begin
        irqmask_reg <= writedata[WIDTH-1:0];
      end
      readdata    <= rd_next;
      irq         <= |(edgecap_reg & irqmask_reg);
    end
  end

endmodule

// File: tb/tb_soc_system_input_pio_irq.sv
// Scoreboarded bench: three PIO instances (rise/any/fall, widths 4/8/32) share one bus.
module tb_soc_system_input_pio_irq;
  import soc_system_pio_pkg::*;

  localparam int NI   = 3;
  localparam int DBC  = 16;
  localparam int HMAX = 8192;
`ifdef SOC_SYSTEM_PIO_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  typedef struct packed {
    logic [NI-1:0][31:0] rd;
    logic [NI-1:0]       irq;
    logic [31:0]         e;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a;
  logic [7:0]  in_b;
  logic [31:0] in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int total;
  int bad;
  int ecount;
  bit rel_pending;
  exp_t exp_q[$];

  logic [31:0] nx_in   [NI];
  logic [31:0] in_hist [NI][HMAX];
  logic [31:0] filt_hist [NI][HMAX];
  logic [31:0] m_cap  [NI];
  logic [31:0] m_mask [NI];
  int          run_len [NI][32];
  int          hold [NI];

  soc_system_input_pio_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE), .DEBOUNCE_CYCLES(DBC)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));
  soc_system_input_pio_irq #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(EDGE_ANY), .DEBOUNCE_CYCLES(DBC)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b));
  soc_system_input_pio_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_FALL), .DEBOUNCE_CYCLES(DBC)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic int p_w(int k);
    case (k) 0: return 4; 1: return 8; default: return 32; endcase
  endfunction
  function automatic int p_s(int k);
    case (k) 0: return 2; 1: return 3; default: return 2; endcase
  endfunction
  function automatic int p_e(int k);
    case (k) 0: return EDGE_RISE; 1: return EDGE_ANY; default: return EDGE_FALL; endcase
  endfunction
  function automatic string iname(int k);
    case (k) 0: return "a"; 1: return "b"; default: return "c"; endcase
  endfunction
  function automatic logic [31:0] wmask(int k);
    logic [32:0] t;
    t = (33'd1 << p_w(k)) - 33'd1;
    return t[31:0];
  endfunction
  // Synchronised input after edge e is the input sampled SYNC_STAGES-1 edges earlier.
  function automatic logic [31:0] sync_at(int k, int e);
    int idx;
    idx = e - p_s(k) + 1;
    return (idx < 1) ? 32'h0 : in_hist[k][idx];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic model_reset();
    ecount = 0;
    for (int k = 0; k < NI; k++) begin
      m_cap[k]  = '0;
      m_mask[k] = '0;
      filt_hist[k][0] = '0;
      for (int b = 0; b < 32; b++) run_len[k][b] = 0;
    end
  endtask

  task automatic model_step(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    exp_t ex;
    logic [31:0] wm, f_prev, r_prev, f_new, cur, old, det, clr;
    int e;
    e = ecount;
    ex.e = 32'(e);
    for (int k = 0; k < NI; k++) begin
      wm = wmask(k);
      in_hist[k][e] = nx_in[k] & wm;
      if (!DB_ON) begin
        f_new = sync_at(k, e);
      end else begin
        f_prev = filt_hist[k][e-1];
        r_prev = sync_at(k, e-1);
        f_new  = f_prev;
        for (int b = 0; b < 32; b++) begin
          if (r_prev[b] != f_prev[b]) begin
            run_len[k][b]++;
            if (run_len[k][b] == DBC) begin
              f_new[b] = r_prev[b];
              run_len[k][b] = 0;
            end
          end else begin
            run_len[k][b] = 0;
          end
        end
      end
      filt_hist[k][e] = f_new;
      det = '0;
      if (e >= p_s(k) + 2 + (DB_ON ? DBC : 0)) begin
        cur = filt_hist[k][e-1];
        old = (e >= 2) ? filt_hist[k][e-2] : 32'h0;
        case (p_e(k))
          EDGE_RISE: det = cur & ~old;
          EDGE_FALL: det = ~cur & old;
          default:   det = cur ^ old;
        endcase
      end
      case (a)
        2'd0:    ex.rd[k] = filt_hist[k][e-1];
        2'd2:    ex.rd[k] = m_mask[k];
        2'd3:    ex.rd[k] = m_cap[k];
        default: ex.rd[k] = '0;
      endcase
      ex.irq[k] = |(m_cap[k] & m_mask[k]);
      clr = (cs && !wn && a == 2'd3) ? (wd & wm) : 32'h0;
      m_cap[k] = (m_cap[k] & ~clr) | det;
      if (cs && !wn && a == 2'd2) m_mask[k] = wd & wm;
    end
    exp_q.push_back(ex);
  endtask

  task automatic cycle(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_a = nx_in[0][3:0];
    in_b = nx_in[1][7:0];
    in_c = nx_in[2];
    if (rel_pending) begin
      reset_n = 1'b1;
      rel_pending = 1'b0;
    end
    ecount++;
    model_step(cs, wn, a, wd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_a"}, rd_a, 32'h0);
    check({tag, "_rd_b"}, rd_b, 32'h0);
    check({tag, "_rd_c"}, rd_c, 32'h0);
    check({tag, "_irq"}, {29'h0, irq_c, irq_b, irq_a}, 32'h0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rel_pending = 1'b1;
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int k = 0; k < NI; k++) nx_in[k] = v;
  endtask

  task automatic reads(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, a, $urandom);
  endtask

  task automatic rand_phase(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NI; k++) begin
        if (hold[k] == 0) begin
          nx_in[k] = $urandom;
          hold[k]  = $urandom_range(1, 40);
        end else begin
          hold[k]--;
        end
      end
      r = $urandom_range(0, 9);
      if (r < 6)      cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
      else if (r < 8) cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
      else            cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
    end
  endtask

  // Monitor: one expected response per clock, compared just after the edge.
  always @(posedge clk) begin
    exp_t ex;
    #1;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      check($sformatf("rd_a e=%0d", ex.e), rd_a, ex.rd[0]);
      check($sformatf("rd_b e=%0d", ex.e), rd_b, ex.rd[1]);
      check($sformatf("rd_c e=%0d", ex.e), rd_c, ex.rd[2]);
      check($sformatf("irq_a e=%0d", ex.e), 32'(irq_a), 32'(ex.irq[0]));
      check($sformatf("irq_b e=%0d", ex.e), 32'(irq_b), 32'(ex.irq[1]));
      check($sformatf("irq_c e=%0d", ex.e), 32'(irq_c), 32'(ex.irq[2]));
    end
  end

  initial begin
    int settle;
    total = 0;
    bad = 0;
    settle = DB_ON ? (DBC + 12) : 8;
    reset_n = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    address = 2'd0;
    writedata = '0;
    set_all(32'hF);
    in_a = 4'hF;
    in_b = 8'h0F;
    in_c = 32'hF;
    rel_pending = 1'b0;
    for (int k = 0; k < NI; k++) hold[k] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rel_pending = 1'b1;

    // Inputs high through reset: DATA follows, no capture.
    for (int i = 0; i < settle + 6; i++) cycle(1'b1, 1'b1, (i % 2) ? 2'd3 : 2'd0, '0);

    cycle(1'b1, 1'b0, 2'd2, 32'h1);
    set_all(32'h0);
    reads(settle, 2'd3);
    cycle(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
    reads(3, 2'd3);

    // Single rising edge on bit 0, clear it, then a no-op clear.
    set_all(32'h1);
    reads(settle, 2'd3);
    cycle(1'b1, 1'b0, 2'd3, 32'h1);
    reads(3, 2'd3);
    cycle(1'b1, 1'b0, 2'd3, 32'h0);
    reads(2, 2'd3);

    // Bit 2 edge lands in the same cycle as its clear on instance a.
    set_all(32'h5);
    cycle(1'b1, 1'b1, 2'd3, '0);
    reads(p_s(0) - 1 + (DB_ON ? DBC : 0), 2'd3);
    cycle(1'b1, 1'b0, 2'd3, 32'h4);
    reads(3, 2'd3);

    // Bit 7 high then low with a clear between the two edges.
    cycle(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF);
    set_all(32'h85);
    reads(settle, 2'd3);
    cycle(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
    reads(3, 2'd1);
    set_all(32'h05);
    reads(settle, 2'd3);
    reads(2, 2'd1);

    // Short glitch then a longer pulse on bit 1.
    set_all(32'h07);
    reads(10, 2'd0);
    set_all(32'h05);
    reads(settle, 2'd3);
    set_all(32'h07);
    reads(20, 2'd0);
    set_all(32'h05);
    reads(settle, 2'd3);

    rand_phase(1500);
    mid_reset();
    rand_phase(1000);

    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
